wb_regfile_stage: RTL and testbench

Final pipeline stage. It registers the MEM-to-WB bus and commits results into an internal 32x32 general register file. It also serves the two ID-stage read ports with same-cycle write bypass and drives the commit trace (debug_wb_*). It exports its pending write as a forwarding bus for ID.

---
 rtl/wb_regfile_stage_pkg.sv | 31 +++
 rtl/wb_regfile_stage_regfile.sv | 63 ++++++
 rtl/wb_regfile_stage.sv | 84 ++++++++
 tb/tb_wb_regfile_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_stage_pkg.sv
// Shared widths, stall encoding and bus payload layouts for the writeback stage.
package wb_regfile_stage_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned RF_AW        = 5;
    localparam int unsigned RF_DEPTH     = 32;
    localparam int unsigned STALL_W      = 6;
    localparam int unsigned MEM_TO_WB_WD = 70;
    localparam int unsigned WB_TO_RF_WD  = 38;
    localparam int unsigned STALL_MEM_WB = 4;
    localparam int unsigned STALL_WB     = 5;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}
    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic             rf_we;
        logic [RF_AW-1:0] rf_waddr;
        logic [XLEN-1:0]  rf_wdata;
    } mem_to_wb_t;

    // {we[37], waddr[36:32], wdata[31:0]}
    typedef struct packed {
        logic             we;
        logic [RF_AW-1:0] waddr;
        logic [XLEN-1:0]  wdata;
    } wb_to_rf_t;

endpackage

// File: rtl/wb_regfile_stage_regfile.sv
// 32x32 general register file: one write port, two read ports with optional write bypass.
module wb_regfile_stage_regfile
    import wb_regfile_stage_pkg::*;
#(
    parameter bit BYPASS_EN    = 1'b1,
    parameter bit REG_RST_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [RF_AW-1:0] i_waddr,
    input  logic [XLEN-1:0]  i_wdata,
    input  logic [RF_AW-1:0] i_raddr1,
    input  logic [RF_AW-1:0] i_raddr2,
    output logic [XLEN-1:0]  o_rdata1,
    output logic [XLEN-1:0]  o_rdata2
);

    logic [XLEN-1:0] r_regs [RF_DEPTH];
    logic            w_wr;

    assign w_wr = i_we && (i_waddr != RF_AW'(0));

    generate
        if (REG_RST_ZERO) begin : g_rst_zero
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < int'(RF_DEPTH); i++) begin
                        r_regs[i] <= '0;
                    end
                end else if (w_wr) begin
                    r_regs[i_waddr] <= i_wdata;
                end
            end
        end else begin : g_no_rst
            // Contents survive reset; the write is already suppressed while rst is high.
            always_ff @(posedge clk) begin
                if (w_wr && !rst) begin
                    r_regs[i_waddr] <= i_wdata;
                end
            end
        end
    endgenerate

    function automatic logic [XLEN-1:0] read_port(input logic [RF_AW-1:0] addr);
        logic [XLEN-1:0] data;
        data = '0;
        if (addr != RF_AW'(0)) begin
            if (BYPASS_EN && w_wr && (addr == i_waddr)) begin
                data = i_wdata;
            end else begin
                data = r_regs[addr];
            end
        end
        return data;
    endfunction

    always_comb begin
        o_rdata1 = read_port(i_raddr1);
        o_rdata2 = read_port(i_raddr2);
    end

endmodule

// File: rtl/wb_regfile_stage.sv
// Writeback stage: MEM/WB pipeline register, single-shot commit into the register file,
// ID forwarding bus and commit trace.
module wb_regfile_stage
    import wb_regfile_stage_pkg::*;
#(
    parameter bit BYPASS_EN    = 1'b1,
    parameter bit REG_RST_ZERO = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_W-1:0]      stall,
    input  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    input  logic [RF_AW-1:0]        raddr1,
    input  logic [RF_AW-1:0]        raddr2,
    output logic [XLEN-1:0]         rdata1,
    output logic [XLEN-1:0]         rdata2,
    output logic [WB_TO_RF_WD-1:0]  wb_to_rf_bus,
    output logic [XLEN-1:0]         debug_wb_pc,
    output logic [3:0]              debug_wb_rf_wen,
    output logic [RF_AW-1:0]        debug_wb_rf_wnum,
    output logic [XLEN-1:0]         debug_wb_rf_wdata
);

    mem_to_wb_t r_wb;
    logic       r_fired;
    mem_to_wb_t w_in;
    logic       w_load_bubble;
    logic       w_load_bus;
    logic       w_wen_eff;
    wb_to_rf_t  w_wb_to_rf;
    logic       w_unused_stall;

    assign w_in           = mem_to_wb_t'(mem_to_wb_bus);
    assign w_load_bubble  = (stall[STALL_MEM_WB] == STOP) && (stall[STALL_WB] == NO_STOP);
    assign w_load_bus     = (stall[STALL_MEM_WB] == NO_STOP);
    assign w_unused_stall = ^stall[STALL_MEM_WB-1:0];

    // r_fired marks a held instruction whose write already committed, so it never repeats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb    <= '0;
            r_fired <= 1'b0;
        end else if (w_load_bubble) begin
            r_wb    <= '0;
            r_fired <= 1'b0;
        end else if (w_load_bus) begin
            r_wb    <= w_in;
            r_fired <= 1'b0;
        end else if (r_wb.rf_we) begin
            r_fired <= 1'b1;
        end
    end

    assign w_wen_eff = r_wb.rf_we && !r_fired && (r_wb.rf_waddr != RF_AW'(0));

    wb_regfile_stage_regfile #(
        .BYPASS_EN    (BYPASS_EN),
        .REG_RST_ZERO (REG_RST_ZERO)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_wen_eff),
        .i_waddr  (r_wb.rf_waddr),
        .i_wdata  (r_wb.rf_wdata),
        .i_raddr1 (raddr1),
        .i_raddr2 (raddr2),
        .o_rdata1 (rdata1),
        .o_rdata2 (rdata2)
    );

    always_comb begin
        w_wb_to_rf       = '0;
        w_wb_to_rf.we    = w_wen_eff;
        w_wb_to_rf.waddr = r_wb.rf_waddr;
        w_wb_to_rf.wdata = r_wb.rf_wdata;
    end

    assign wb_to_rf_bus      = w_wb_to_rf;
    assign debug_wb_pc       = r_wb.pc;
    assign debug_wb_rf_wen   = {4{w_wen_eff}};
    assign debug_wb_rf_wnum  = r_wb.rf_waddr;
    assign debug_wb_rf_wdata = r_wb.rf_wdata;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Self-checking bench: bypass and no-bypass instances share stimulus and are compared
// against a transaction-level model of the stage and register file.
module tb_wb_regfile_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [69:0] mem_to_wb_bus;
    logic [4:0]  raddr1, raddr2;

    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic [37:0] wb_b, wb_n;
    logic [31:0] pc_b, pc_n, wdat_b, wdat_n;
    logic [3:0]  wen_b, wen_n;
    logic [4:0]  wnum_b, wnum_n;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    localparam logic [5:0] S_RUN    = 6'b000000;
    localparam logic [5:0] S_HOLD   = 6'b110000;
    localparam logic [5:0] S_BUBBLE = 6'b010000;

    always #5 clk = ~clk;

    wb_regfile_stage #(.BYPASS_EN(1'b1), .REG_RST_ZERO(1'b1)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .mem_to_wb_bus(mem_to_wb_bus),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_b), .rdata2(rd2_b),
        .wb_to_rf_bus(wb_b), .debug_wb_pc(pc_b), .debug_wb_rf_wen(wen_b),
        .debug_wb_rf_wnum(wnum_b), .debug_wb_rf_wdata(wdat_b)
    );

    wb_regfile_stage #(.BYPASS_EN(1'b0), .REG_RST_ZERO(1'b1)) dut_n (
        .clk(clk), .rst(rst), .stall(stall), .mem_to_wb_bus(mem_to_wb_bus),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_n), .rdata2(rd2_n),
        .wb_to_rf_bus(wb_n), .debug_wb_pc(pc_n), .debug_wb_rf_wen(wen_n),
        .debug_wb_rf_wnum(wnum_n), .debug_wb_rf_wdata(wdat_n)
    );

    // Reference model: the instruction sitting in WB and whether it has already committed.
    logic [31:0] m_regs [32];
    logic [31:0] m_pc, m_wdata;
    logic        m_we, m_done;
    logic [4:0]  m_waddr;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pc = '0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_done = 1'b0;
    endtask

    function automatic logic m_wen();
        return m_we && !m_done && (m_waddr != 5'd0);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && m_wen() && a == m_waddr) return m_wdata;
        return m_regs[a];
    endfunction

    task automatic model_step();
        if (m_wen()) m_regs[m_waddr] = m_wdata;
        if (stall[4] && !stall[5]) begin
            m_pc = '0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_done = 1'b0;
        end else if (!stall[4]) begin
            {m_pc, m_we, m_waddr, m_wdata} = mem_to_wb_bus;
            m_done = 1'b0;
        end else if (m_we) begin
            m_done = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic e;
        e = m_wen();
        chk("pc",      pc_b,   m_pc);
        chk("wen",     wen_b,  {4{e}});
        chk("wnum",    wnum_b, m_waddr);
        chk("wdata",   wdat_b, m_wdata);
        chk("wb_bus",  wb_b,   {e, m_waddr, m_wdata});
        chk("rd1_byp", rd1_b,  exp_rd(raddr1, 1'b1));
        chk("rd2_byp", rd2_b,  exp_rd(raddr2, 1'b1));
        chk("rd1_nb",  rd1_n,  exp_rd(raddr1, 1'b0));
        chk("rd2_nb",  rd2_n,  exp_rd(raddr2, 1'b0));
        chk("pc_nb",   pc_n,   m_pc);
        chk("wen_nb",  wen_n,  {4{e}});
        chk("wb_nb",   wb_n,   {e, m_waddr, m_wdata});
        chk("trace_nb", {wnum_n, wdat_n}, {m_waddr, m_wdata});
    endtask

    function automatic logic [69:0] mk_bus(input logic [31:0] pc, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
        return {pc, we, wa, wd};
    endfunction

    task automatic drive(input logic [5:0] s, input logic [69:0] b,
                         input logic [4:0] a1, input logic [4:0] a2);
        stall = s; mem_to_wb_bus = b; raddr1 = a1; raddr2 = a2;
        @(negedge clk);
        check_all();
        if (wen_b == 4'hF) pulses++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_pc",  pc_b, 32'd0);
        chk("rst_wen", wen_b, 4'd0);
        chk("rst_bus", wb_b, 38'd0);
        check_all();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [5:0] s;
        logic [4:0] a1, a2;
        int r;

        rst = 1'b1; stall = '0; mem_to_wb_bus = '0; raddr1 = '0; raddr2 = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all();
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic write, bypass then array read
        drive(S_RUN, mk_bus(32'hBFC00000, 1'b1, 5'd5, 32'h12345678), 5'd5, 5'd5);
        tick();
        drive(S_RUN, '0, 5'd5, 5'd5);
        chk("t1_wen",  wen_b, 4'hF);
        chk("t1_wnum", wnum_b, 5'd5);
        chk("t1_byp",  rd1_b, 32'h12345678);
        tick();
        drive(S_RUN, '0, 5'd5, 5'd0);
        chk("t1_arr",  rd1_b, 32'h12345678);
        tick();

        // Write to r0 is suppressed
        drive(S_RUN, mk_bus(32'hBFC00004, 1'b1, 5'd0, 32'hFFFFFFFF), 5'd0, 5'd0);
        tick();
        drive(S_RUN, '0, 5'd0, 5'd0);
        chk("t2_wen", wen_b, 4'h0);
        chk("t2_we",  wb_b[37], 1'b0);
        chk("t2_rd0", rd1_b, 32'd0);
        tick();

        // Multi-cycle hold: one trace pulse only
        drive(S_RUN, mk_bus(32'hBFC00008, 1'b1, 5'd8, 32'hA5A5A5A5), 5'd8, 5'd8);
        tick();
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            drive(S_HOLD, mk_bus(32'h11111111, 1'b1, 5'd8, 32'h0BAD0BAD), 5'd8, 5'd8);
            chk("t3_we", wb_b[37], (k == 0));
            chk("t3_r8", rd1_b, 32'hA5A5A5A5);
            tick();
        end
        chk("t3_pulses", pulses, 1);

        // Bubble load while a valid bus is offered
        drive(S_BUBBLE, mk_bus(32'h22222222, 1'b1, 5'd8, 32'h5A5A5A5A), 5'd8, 5'd0);
        tick();
        drive(S_RUN, '0, 5'd8, 5'd8);
        chk("t4_pc",  pc_b, 32'd0);
        chk("t4_wen", wen_b, 4'h0);
        chk("t4_r8",  rd1_b, 32'hA5A5A5A5);
        tick();

        // Same address on both ports during a write, with and without bypass
        drive(S_RUN, mk_bus(32'hBFC00010, 1'b1, 5'd3, 32'h00000042), 5'd3, 5'd3);
        tick();
        drive(S_RUN, '0, 5'd3, 5'd3);
        chk("t5_b1", rd1_b, 32'h42);
        chk("t5_b2", rd2_b, 32'h42);
        chk("t5_n1", rd1_n, 32'h0);
        chk("t5_n2", rd2_n, 32'h0);
        tick();
        drive(S_RUN, '0, 5'd3, 5'd3);
        chk("t5_n1_next", rd1_n, 32'h42);
        chk("t5_n2_next", rd2_n, 32'h42);
        tick();

        // Asynchronous reset during a held, still-pending write
        drive(S_RUN, mk_bus(32'hBFC00014, 1'b1, 5'd9, 32'hDEADBEEF), 5'd9, 5'd9);
        tick();
        pulses = 0;
        stall = S_HOLD; mem_to_wb_bus = '0;
        async_reset();
        drive(S_RUN, '0, 5'd9, 5'd9);
        chk("t6_r9", rd1_b, 32'd0);
        chk("t6_pulses", pulses, 0);
        tick();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       s = {2'b00, 4'($urandom)};
            else if (r < 8)  s = {2'b11, 4'($urandom)};
            else if (r == 8) s = {2'b01, 4'($urandom)};
            else             s = 6'($urandom);
            a1 = ($urandom_range(0, 1) == 0) ? m_waddr : 5'($urandom);
            a2 = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom);
            drive(s, mk_bus($urandom, 1'($urandom), 5'($urandom), $urandom), a1, a2);
            if ($urandom_range(0, 99) == 0) async_reset();
            else tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
